// File: rtl/conv_window_buf.sv
// Multi-channel K x K sliding-window line buffer for raster-order pixel streams.
// One pixel per valid cycle in; registered window, valid pulse and last-of-frame out.
module conv_window_buf #(
  parameter int WIDTH    = 13,
  parameter int HEIGHT   = 13,
  parameter int CHANNELS = 8,
  parameter int PIX_W    = 1,
  parameter int K        = 3,
  parameter int STRIDE   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic                            sof_in,
  input  logic [CHANNELS*PIX_W-1:0]       pixel_in,
  output logic [CHANNELS*K*K*PIX_W-1:0]   window_out,
  output logic                            valid_out,
  output logic                            last_out
);

  localparam int PXW  = CHANNELS * PIX_W;
  localparam int TAPW = K * K * PIX_W;
  localparam int WINW = CHANNELS * TAPW;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int SW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] FIRST_C = CW'(K - 1);
  localparam logic [RW-1:0] FIRST_R = RW'(K - 1);
  localparam logic [CW-1:0] LAST_C  = CW'(K - 1 + STRIDE * ((WIDTH - K) / STRIDE));
  localparam logic [RW-1:0] LAST_R  = RW'(K - 1 + STRIDE * ((HEIGHT - K) / STRIDE));
  localparam logic [SW-1:0] PH_MAX  = SW'(STRIDE - 1);
  localparam logic [SW-1:0] PH_HIT  = SW'((K - 1) % STRIDE);

  logic [RW-1:0]   row_q, row_d, cur_row;
  logic [CW-1:0]   col_q, col_d, cur_col;
  logic [SW-1:0]   rph_q, rph_d, cur_rph;
  logic [SW-1:0]   cph_q, cph_d, cur_cph;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [WINW-1:0] win_out_q, win_out_d;
  logic            col_wrap, emit;

  logic [PXW-1:0]  lb_q  [K-1][WIDTH];
  logic [PXW-1:0]  lb_d  [K-1][WIDTH];
  logic [PXW-1:0]  tap_q [K][K];
  logic [PXW-1:0]  tap_d [K][K];
  logic [PXW-1:0]  col_vec [K];

  // Phase counters track position mod STRIDE so no divider is needed.
  function automatic logic [SW-1:0] ph_step(input logic [SW-1:0] p);
    return (p == PH_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cur_row  = sof_in ? '0 : row_q;
    cur_col  = sof_in ? '0 : col_q;
    cur_rph  = sof_in ? '0 : rph_q;
    cur_cph  = sof_in ? '0 : cph_q;
    col_wrap = (cur_col == COL_MAX);
    emit     = valid_in && (cur_row >= FIRST_R) && (cur_col >= FIRST_C) &&
               (cur_rph == PH_HIT) && (cur_cph == PH_HIT);
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    rph_d = rph_q;
    cph_d = cph_q;
    if (valid_in) begin
      col_d = col_wrap ? '0 : cur_col + 1'b1;
      cph_d = col_wrap ? '0 : ph_step(cur_cph);
      if (col_wrap) begin
        row_d = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
        rph_d = (cur_row == ROW_MAX) ? '0 : ph_step(cur_rph);
      end else begin
        row_d = cur_row;
        rph_d = cur_rph;
      end
    end
  end

  // Line buffer i holds row r-(K-1)+i at each column; the incoming pixel cascades upward.
  always_comb begin
    lb_d  = lb_q;
    tap_d = tap_q;
    for (int i = 0; i < K - 1; i++) begin
      col_vec[i] = lb_q[i][cur_col];
    end
    col_vec[K-1] = pixel_in;
    if (valid_in) begin
      for (int i = 0; i < K - 2; i++) begin
        lb_d[i][cur_col] = lb_q[i+1][cur_col];
      end
      lb_d[K-2][cur_col] = pixel_in;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          tap_d[i][j] = tap_q[i][j+1];
        end
        tap_d[i][K-1] = col_vec[i];
      end
    end
  end

  always_comb begin
    valid_d   = emit;
    last_d    = emit && (cur_row == LAST_R) && (cur_col == LAST_C);
    win_out_d = win_out_q;
    if (emit) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            win_out_d[c*TAPW + (i*K+j)*PIX_W +: PIX_W] = tap_d[i][j][c*PIX_W +: PIX_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      rph_q     <= '0;
      cph_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      win_out_q <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      rph_q     <= rph_d;
      cph_q     <= cph_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      win_out_q <= win_out_d;
    end
  end

  // Storage is not reset; stale contents are never emitted because emit is gated by position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lb_q  <= lb_d;
      tap_q <= tap_d;
    end
  end

  assign window_out = win_out_q;
  assign valid_out  = valid_q;
  assign last_out   = last_q;

endmodule

// File: tb/tb_conv_window_buf.sv
// Bench for conv_window_buf: three parameterisations checked every cycle against
// a frame-image reference model, plus literal checks on counts and taps.
module tb_conv_window_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        val_i [3];
  logic        sof_i [3];
  logic        rst_i [3];
  logic [63:0] pix_i [3];

  wire           vo   [3];
  wire           lo   [3];
  wire           ev_w [3];
  wire           el_w [3];
  wire [1599:0]  win_w [3];
  wire [1599:0]  exp_w [3];

  int n_cmp = 0;
  int n_fail = 0;
  int pulses [3];
  int lasts [3];
  int first_last_at [3];
  int last_at [3];
  int first_acc [3];
  int acc [3];
  int acc122;
  logic [1599:0] first_win [3];
  logic [63:0]   drv2 [64];

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W   = (g == 2) ? 8 : 13;
    localparam int H   = (g == 2) ? 8 : 13;
    localparam int CH  = (g == 2) ? 16 : 8;
    localparam int PB  = (g == 2) ? 4 : 1;
    localparam int KK  = (g == 2) ? 5 : 3;
    localparam int S   = (g == 1) ? 2 : 1;
    localparam int PXW = CH * PB;
    localparam int WW  = CH * KK * KK * PB;

    logic [PXW-1:0] pin;
    logic [WW-1:0]  d_win;
    logic           d_v, d_l;
    assign pin = pix_i[g][PXW-1:0];

    conv_window_buf #(.WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .PIX_W(PB), .K(KK), .STRIDE(S)) dut (
      .clk(clk), .rst(rst_i[g]), .valid_in(val_i[g]), .sof_in(sof_i[g]), .pixel_in(pin),
      .window_out(d_win), .valid_out(d_v), .last_out(d_l));

    // Reference: remember the whole frame, cut the window straight out of it.
    logic [PXW-1:0] img [H][W];
    int mr = 0;
    int mc = 0;
    logic ev = 1'b0;
    logic el = 1'b0;
    logic [WW-1:0] ew = '0;

    always @(posedge clk) begin
      if (rst_i[g]) begin
        mr = 0; mc = 0; ev = 1'b0; el = 1'b0; ew = '0;
      end else if (val_i[g]) begin
        if (sof_i[g]) begin mr = 0; mc = 0; end
        img[mr][mc] = pin;
        ev = (mr >= KK-1) && (mc >= KK-1) && ((mr-KK+1) % S == 0) && ((mc-KK+1) % S == 0);
        el = ev && (mr == H-1-((H-KK) % S)) && (mc == W-1-((W-KK) % S));
        if (ev)
          for (int c = 0; c < CH; c++)
            for (int i = 0; i < KK; i++)
              for (int j = 0; j < KK; j++)
                ew[c*KK*KK*PB + (i*KK+j)*PB +: PB] = img[mr-KK+1+i][mc-KK+1+j][c*PB +: PB];
        mc++;
        if (mc == W) begin
          mc = 0; mr++;
          if (mr == H) mr = 0;
        end
      end else begin
        ev = 1'b0; el = 1'b0;
      end
    end

    assign vo[g]    = d_v;
    assign lo[g]    = d_l;
    assign ev_w[g]  = ev;
    assign el_w[g]  = el;
    assign win_w[g] = 1600'(d_win);
    assign exp_w[g] = 1600'(ew);
  end

  task automatic cycle();
    for (int g = 0; g < 3; g++) if (val_i[g] && !rst_i[g]) acc[g]++;
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (vo[g] !== ev_w[g] || lo[g] !== el_w[g] || win_w[g] !== exp_w[g]) begin
        n_fail++;
        $display("FAIL cfg%0d out: got v=%b l=%b w=%h, want v=%b l=%b w=%h",
                 g, vo[g], lo[g], win_w[g][255:0], ev_w[g], el_w[g], exp_w[g][255:0]);
      end
      if (vo[g] === 1'b1) begin
        pulses[g]++;
        if (pulses[g] == 1) begin first_acc[g] = acc[g]; first_win[g] = win_w[g]; end
        if (g == 0 && pulses[0] == 122) acc122 = acc[0];
        if (lo[g] === 1'b1) begin
          lasts[g]++;
          last_at[g] = pulses[g];
          if (lasts[g] == 1) first_last_at[g] = pulses[g];
        end
      end
    end
  endtask

  task automatic clear_stats();
    for (int g = 0; g < 3; g++) begin
      pulses[g] = 0; lasts[g] = 0; first_last_at[g] = 0;
      last_at[g] = 0; first_acc[g] = 0; acc[g] = 0;
    end
    acc122 = 0;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic logic [63:0] pat(input int idx);
    int r, c;
    logic [63:0] p;
    r = (idx / 13) % 13;
    c = idx % 13;
    p = '0;
    for (int ch = 0; ch < 8; ch++) p[ch] = ((r + c + ch) % 2 == 1);
    return p;
  endfunction

  task automatic idle_all();
    for (int g = 0; g < 3; g++) begin val_i[g] = 1'b0; sof_i[g] = 1'b0; end
  endtask

  initial begin
    int cyc;
    logic [71:0] lit0;
    for (int g = 0; g < 3; g++) begin
      val_i[g] = 1'b0; sof_i[g] = 1'b0; rst_i[g] = 1'b1; pix_i[g] = '0;
    end
    clear_stats();
    repeat (3) cycle();
    for (int g = 0; g < 3; g++) rst_i[g] = 1'b0;
    cycle();

    // Continuous: cfg0 two back-to-back patterned frames, cfg1 stride 2, cfg2 K=5.
    clear_stats();
    for (int i = 0; i < 338; i++) begin
      val_i[0] = 1'b1;     sof_i[0] = (i == 0); pix_i[0] = pat(i);
      val_i[1] = (i < 169); sof_i[1] = (i == 0); pix_i[1] = {$urandom, $urandom};
      val_i[2] = (i < 64);  sof_i[2] = (i == 0); pix_i[2] = {$urandom, $urandom};
      if (i < 64) drv2[i] = pix_i[2];
      cycle();
    end
    idle_all();
    repeat (3) cycle();
    check("c0 pulses", pulses[0], 242);
    check("c0 first pulse after px", first_acc[0], 29);
    check("c0 lasts", lasts[0], 2);
    check("c0 first last pulse", first_last_at[0], 121);
    check("c0 second last pulse", last_at[0], 242);
    check("c0 pulse122 px", acc122, 198);
    lit0 = {4{9'h155, 9'h0AA}};
    n_cmp++;
    if (first_win[0][71:0] !== lit0) begin
      n_fail++;
      $display("FAIL c0 first window: got %h want %h", first_win[0][71:0], lit0);
    end
    check("c1 pulses", pulses[1], 36);
    check("c1 lasts", lasts[1], 1);
    check("c1 last pulse", last_at[1], 36);
    check("c1 first pulse after px", first_acc[1], 29);
    check("c2 pulses", pulses[2], 16);
    check("c2 lasts", lasts[2], 1);
    check("c2 first pulse after px", first_acc[2], 37);
    check("c2 ch15 tap0", int'(first_win[2][1500 +: 4]), int'(drv2[0][63:60]));
    check("c2 ch15 tap24", int'(first_win[2][1596 +: 4]), int'(drv2[36][63:60]));
    check("c2 ch0 tap24", int'(first_win[2][96 +: 4]), int'(drv2[36][3:0]));

    // Random valid at ~50%: same window sequences as continuous streaming.
    clear_stats();
    cyc = 0;
    while ((acc[0] < 169 || acc[1] < 169 || acc[2] < 64) && cyc < 3000) begin
      for (int g = 0; g < 3; g++) begin
        val_i[g] = (acc[g] < ((g == 2) ? 64 : 169)) && ($urandom % 2 == 1);
        sof_i[g] = val_i[g] && (acc[g] == 0);
        pix_i[g] = {$urandom, $urandom};
      end
      cycle();
      cyc++;
    end
    idle_all();
    repeat (3) cycle();
    check("rand c0 accepted", acc[0], 169);
    check("rand c0 pulses", pulses[0], 121);
    check("rand c0 lasts", lasts[0], 1);
    check("rand c1 pulses", pulses[1], 36);
    check("rand c2 pulses", pulses[2], 16);

    // Reset mid-frame at pixel 50, then a sof resync at pixel 40 of the fresh frame.
    clear_stats();
    for (int i = 0; i < 50; i++) begin
      val_i[0] = 1'b1; sof_i[0] = (i == 0); pix_i[0] = {$urandom, $urandom};
      cycle();
    end
    check("rst pre pulses", pulses[0], 20);
    rst_i[0] = 1'b1; sof_i[0] = 1'b0; pix_i[0] = {$urandom, $urandom};
    cycle();
    n_cmp++;
    if (vo[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL valid after rst: got %b want 0", vo[0]);
    end
    rst_i[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      val_i[0] = 1'b1; sof_i[0] = 1'b0; pix_i[0] = {$urandom, $urandom};
      cycle();
    end
    check("post rst 40px pulses", pulses[0], 31);
    clear_stats();
    for (int i = 0; i < 169; i++) begin
      val_i[0] = 1'b1; sof_i[0] = (i == 0); pix_i[0] = {$urandom, $urandom};
      cycle();
    end
    idle_all();
    repeat (3) cycle();
    check("sof pulses", pulses[0], 121);
    check("sof first pulse after px", first_acc[0], 29);
    check("sof lasts", lasts[0], 1);
    check("sof last pulse", last_at[0], 121);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_buf.md
Name: conv_window_buf

Overview:
Parametrised multi-channel sliding-window line buffer for the conv stages of the MNIST pipeline. Accepts one raster-order pixel per cycle, carrying all channels, under a valid qualifier. Emits a registered K x K window of every channel with valid, stride and end-of-frame marking. Sits between a conv/pool stage output and the next conv MAC array. Generalises the fixed 3x3, 8-channel, 1-bit, always-streaming buffer.

Parameters:
WIDTH, 13, frame width in pixels (>= K)
HEIGHT, 13, frame height in pixels (>= K)
CHANNELS, 8, channels per pixel
PIX_W, 1, bits per channel sample
K, 3, kernel size (window is K x K, K >= 2)
STRIDE, 1, window step in both row and column (>= 1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
valid_in  in  1  pixel_in is valid this cycle
sof_in  in  1  with valid_in: this pixel is (row 0, col 0) of a new frame
pixel_in  in  CHANNELS*PIX_W  channel c at [c*PIX_W +: PIX_W]
window_out  out  CHANNELS*K*K*PIX_W  registered window
valid_out  out  1  window_out valid (single-cycle pulse per window)
last_out  out  1  with valid_out: last window of the frame

Behaviour:
- Clock clk; reset rst, synchronous, active-high. On rst: window_out=0, valid_out=0, last_out=0, row/col counters=0, stride phase counters=0. Line-buffer RAM contents need no reset; they are never exposed because valid is gated by the counters.
- No backpressure. Every cycle with valid_in=1 accepts one pixel. Cycles with valid_in=0 hold all state. valid_out/last_out are 0 on the cycle after a non-accepting cycle.
- Position: col 0..WIDTH-1, row 0..HEIGHT-1, advanced per accepted pixel. col wraps to 0 and increments row. After (HEIGHT-1, WIDTH-1), both wrap to 0 (the next frame follows back-to-back).
- sof_in=1 with valid_in=1: the accepted pixel is treated as (0,0). Counters and phases restart from it regardless of their previous value. sof_in is ignored when valid_in=0.
- Storage: K-1 line buffers of WIDTH entries x CHANNELS*PIX_W, plus a K x K register window per channel that shifts left by one column per accepted pixel.
- Window emit condition for accepted pixel (r,c):
  - r >= K-1 and c >= K-1;
  - (r-(K-1)) mod STRIDE == 0 and (c-(K-1)) mod STRIDE == 0. Implement the mod with phase counters, not dividers.
- Windows never straddle a row wrap or a frame boundary.
- Latency: valid_out=1 exactly one cycle after accepting the bottom-right pixel of a window. window_out is registered in the same cycle.
- Window packing:
  - channel c at [c*K*K*PIX_W +: K*K*PIX_W];
  - within a channel, tap t = i*K + j at [t*PIX_W +: PIX_W];
  - i = 0 is the top (oldest) row and j = 0 the leftmost (oldest) column;
  - tap K*K-1 is the newest pixel.
- window_out holds its last value while valid_out=0.
- last_out=1 with the window whose bottom-right is the last emitted position of the frame, i.e. r = K-1+S*floor((HEIGHT-K)/S) and c = K-1+S*floor((WIDTH-K)/S), with S = STRIDE.
- Windows per frame: (floor((HEIGHT-K)/S)+1) * (floor((WIDTH-K)/S)+1). Defaults give 121.
- Reset mid-frame: outputs go to 0 on the next edge. The first pixel after reset is (0,0). No window from the aborted frame is emitted.
- Simultaneous rst and valid_in: rst wins, and the pixel is dropped.

Test Plan:
1. Defaults, 169 pixels with valid_in held high and pixel_in = {ch7..ch0} = bit c set iff (r+c+ch) odd -> exactly 121 valid_out pulses. The first pulse is the cycle after pixel index 28 (r2,c2). Every window_out matches the reference model packing. last_out appears only on pulse 121.
2. Same frame, valid_in pseudo-random at 50% -> identical window sequence. valid_out only on cycles following an accepted emit pixel. No two consecutive pulses unless their pixels were accepted back-to-back.
3. STRIDE=2, WIDTH=HEIGHT=13 -> 36 windows, with bottom-right positions (r,c) in {2,4,..,12}^2. last_out on (12,12).
4. K=5, CHANNELS=16, PIX_W=4, WIDTH=HEIGHT=8 -> 16 windows. Tap 0 of channel 15 in the first window equals pixel (0,0) ch15. Tap 24 equals pixel (4,4).
5. Two back-to-back frames, 338 continuous pixels -> 242 windows. last_out on pulses 121 and 242. Pulse 122 follows pixel (2,2) of frame 2.
6. rst asserted at accepted pixel 50, then sof_in pulse mid-frame at pixel 40 of a fresh frame:
   - valid_out=0 the cycle after rst;
   - the post-reset stream produces 121 correct windows;
   - sof resync restarts counting, and the first window follows 29 pixels after the sof pixel.
